instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch stage feeding instructionMemory: holds the PC and drives readAddress.
//   Captures the returned instruction into an IF/ID pipeline register for decode.
//   Handles stalls, branch/jump redirects with flush, and end-of-program detection.
// PARAMETERS
//   RESET_PC    0  byte address loaded into PC on reset; must be word-aligned and in range
//   IMEM_DEPTH  6  number of 32-bit words in instruction memory; word index >= this is out of range
// PORTS
//   clock           input   1   rising-edge clock; the only clock
//   reset           input   1   asynchronous, active-high reset
//   stall           input   1   hazard unit: hold PC and IF/ID contents
//   branchTaken     input   1   from ID: redirect to branchTarget
//   branchTarget    input  32   byte address of the branch destination
//   jump            input   1   from ID: redirect to jump target
//   jumpIndex       input  26   instr[25:0] of the jump in ID
//   instruction     input  32   from instructionMemory, combinational on readAddress
//   readAddress     output 32   = pc; drives instructionMemory
//   ifidInstruction output 32   IF/ID latched instruction
//   ifidPcPlus4     output 32   IF/ID latched pc+4
//   ifidValid       output  1   IF/ID holds a real instruction (0 = bubble)
//   halted          output  1   PC out of range and IF/ID empty
//   fetchCount      output 32   number of instructions delivered to IF/ID
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC; ifidInstruction=0; ifidPcPlus4=0;
//     ifidValid=0; fetchCount=0; halted=0.
//   outOfRange = (pc>>2) >= IMEM_DEPTH. readAddress = pc always, combinational.
//   Latency: instruction at pc appears on ifidInstruction 1 cycle after pc is presented.
//   Next-state priority, evaluated each rising edge:
//     1 jump:        pc <= {ifidPcPlus4[31:28], jumpIndex, 2'b00}; flush IF/ID
//     2 branchTaken: pc <= {branchTarget[31:2], 2'b00}; flush IF/ID
//     3 stall:       pc, IF/ID, fetchCount hold
//     4 outOfRange:  pc holds; IF/ID <= bubble
//     5 otherwise:   pc <= pc+4; IF/ID <= {instruction, pc+4, valid=1}; fetchCount++
//   Flush or bubble: ifidInstruction=0 (NOP), ifidPcPlus4=0, ifidValid=0.
//   jump and branchTaken asserted together: jump wins.
//   Redirect plus stall: redirect wins, because the redirecting instruction is in ID.
//   Target bits [1:0] are forced to 0; misalignment is not flagged.
//   PC arithmetic is mod 2^32: 0xFFFFFFFC+4 wraps to 0. fetchCount also wraps.
//   A redirect clears outOfRange and fetch resumes the next cycle.
//   halted = outOfRange & ~ifidValid, combinational. It drops as soon as pc returns in range.
//   Reset mid-stall or mid-redirect: reset overrides everything, nothing is retained.
//   Control inputs are sampled only at the edge; glitches between edges are ignored.
// STRUCTURE
//   Shared package fetch_pkg:
//     NOP_INSTR = 32'h0000_0000; PC_INCREMENT = 32'd4.
//     Typedef of the IF/ID bundle {instruction, pcPlus4, valid}.
//   One sub-module, pc_register: async-reset PC flop with load and hold enables.
//   IF/ID register, next-PC mux and fetchCount live in this module.
// TESTING
//   1 Reset, memory words 0..5 distinct, no stall: readAddress 0,4,8,...,20;
//     ifidInstruction = mem[k] one cycle later; fetchCount=6; then halted=1 and pc holds at 24.
//   2 Stall for 3 cycles at pc=8: pc stays 8, IF/ID keeps mem[1], fetchCount frozen;
//     after release the next capture is mem[2].
//   3 branchTaken with branchTarget=0x4 while pc=12: next pc=4, ifidValid=0 for 1 cycle,
//     then mem[1] is captured.
//   4 jump with jumpIndex=0x2 and ifidPcPlus4=0x8, together with branchTaken and stall:
//     pc=8 (jump wins), IF/ID flushed.
//   5 Assert reset asynchronously between edges while pc=16, ifidValid=1:
//     outputs go to reset values immediately, before the next edge.
//   6 Redirect while halted to branchTarget=0x7: pc=4 (bits[1:0] cleared),
//     halted=0, fetch resumes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The IF/ID bundle and the sequential-PC helper are used by the top and by pc_register.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_INCREMENT = 32'd4;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifid_t;

    // A flushed or bubbled IF/ID slot carries a NOP and no valid bit.
    localparam ifid_t IFID_BUBBLE = '{NOP_INSTR, 32'd0, 1'b0};

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INCREMENT;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control and data bus between the fetch stage, the decode stage, the hazard unit and
// instruction memory. The fetch unit uses the master modport.
interface instruction_fetch_unit_if;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [25:0] jumpIndex;
    logic [31:0] instruction;
    logic [31:0] readAddress;
    logic [31:0] ifidInstruction;
    logic [31:0] ifidPcPlus4;
    logic        ifidValid;
    logic        halted;
    logic [31:0] fetchCount;

    modport master (
        input  stall, branchTaken, branchTarget, jump, jumpIndex, instruction,
        output readAddress, ifidInstruction, ifidPcPlus4, ifidValid, halted, fetchCount
    );

    modport slave (
        output stall, branchTaken, branchTarget, jump, jumpIndex, instruction,
        input  readAddress, ifidInstruction, ifidPcPlus4, ifidValid, halted, fetchCount
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop: load takes priority over hold, otherwise it advances one word.
// Arithmetic is mod 2^32, so the last word address wraps to zero.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        hold,
    input  logic [31:0] load_value,
    output logic [31:0] pc
);

    logic [31:0] pc_r;

    // PC state: redirect load, hold, or sequential advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (load) begin
            pc_r <= load_value;
        end else if (hold) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= next_seq_pc(pc_r);
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction memory address from the PC, captures the returned
// word into the IF/ID register and handles stall, jump/branch redirect and end of program.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    logic [31:0] pc_s;
    logic        out_of_range_s;
    logic        redirect_s;
    logic [31:0] redirect_pc_s;
    logic        pc_hold_s;
    ifid_t       ifid_r;
    ifid_t       ifid_next_s;
    logic [31:0] fetch_count_r;
    logic [31:0] fetch_count_next_s;

    assign out_of_range_s = (pc_s >> 2) >= 32'(IMEM_DEPTH);
    // Stalls never block a redirect: the redirecting instruction already sits in ID.
    assign pc_hold_s      = bus.stall | out_of_range_s;

    // Redirect target select; jump outranks a simultaneous branch.
    always_comb begin
        redirect_s    = 1'b0;
        redirect_pc_s = pc_s;
        if (bus.jump) begin
            redirect_s    = 1'b1;
            redirect_pc_s = {ifid_r.pcPlus4[31:28], bus.jumpIndex, 2'b00};
        end else if (bus.branchTaken) begin
            redirect_s    = 1'b1;
            redirect_pc_s = bus.branchTarget & 32'hFFFF_FFFC;
        end else begin
            redirect_s    = 1'b0;
        end
    end

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clock      (clock),
        .reset      (reset),
        .load       (redirect_s),
        .hold       (pc_hold_s),
        .load_value (redirect_pc_s),
        .pc         (pc_s)
    );

    // IF/ID and fetch counter next state, same priority as the PC.
    always_comb begin
        ifid_next_s        = ifid_r;
        fetch_count_next_s = fetch_count_r;
        if (redirect_s) begin
            ifid_next_s = IFID_BUBBLE;
        end else if (bus.stall) begin
            ifid_next_s = ifid_r;
        end else if (out_of_range_s) begin
            ifid_next_s = IFID_BUBBLE;
        end else begin
            ifid_next_s.instruction = bus.instruction;
            ifid_next_s.pcPlus4     = next_seq_pc(pc_s);
            ifid_next_s.valid       = 1'b1;
            fetch_count_next_s      = fetch_count_r + 32'd1;
        end
    end

    // IF/ID pipeline register and delivered-instruction counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid_r        <= IFID_BUBBLE;
            fetch_count_r <= 32'd0;
        end else begin
            ifid_r        <= ifid_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    assign bus.readAddress     = pc_s;
    assign bus.ifidInstruction = ifid_r.instruction;
    assign bus.ifidPcPlus4     = ifid_r.pcPlus4;
    assign bus.ifidValid       = ifid_r.valid;
    assign bus.fetchCount      = fetch_count_r;
    assign bus.halted          = out_of_range_s & ~ifid_r.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a priority-rule model checked every negative edge,
// plus directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (32'd0),
        .IMEM_DEPTH (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // Memory contents: word k holds (k+1) repeated in every nibble.
    function automatic logic [31:0] word(input int k);
        return 32'h1111_1111 * 32'(k + 1);
    endfunction

    always_comb begin
        if (bus.readAddress < 32'd24) bus.instruction = word(int'(bus.readAddress >> 2));
        else                          bus.instruction = 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model of the fetch stage state.
    logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_pc4 = 32'd0, m_count = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_halted;
    assign m_halted = (m_pc >= 32'd24) && !m_valid;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc <= 32'd0; m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0; m_count <= 32'd0;
        end else if (bus.jump) begin
            m_pc <= {m_pc4[31:28], bus.jumpIndex, 2'b00};
            m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
        end else if (bus.branchTaken) begin
            m_pc <= {bus.branchTarget[31:2], 2'b00};
            m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
        end else if (bus.stall) begin
            m_pc <= m_pc;
        end else if (m_pc >= 32'd24) begin
            m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
        end else begin
            m_instr <= word(int'(m_pc >> 2));
            m_pc4   <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_count <= m_count + 32'd1;
            m_pc    <= m_pc + 32'd4;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("model readAddress", bus.readAddress, m_pc);
            chk("model ifidInstruction", bus.ifidInstruction, m_instr);
            chk("model ifidPcPlus4", bus.ifidPcPlus4, m_pc4);
            chk("model ifidValid", {31'd0, bus.ifidValid}, {31'd0, m_valid});
            chk("model halted", {31'd0, bus.halted}, {31'd0, m_halted});
            chk("model fetchCount", bus.fetchCount, m_count);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        bus.stall = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = 32'd0;
        bus.jump = 1'b0; bus.jumpIndex = 26'd0;
    endtask

    initial begin
        clear_ctl();
        #1;
        chk("reset readAddress", bus.readAddress, 32'd0);
        chk("reset ifidValid", {31'd0, bus.ifidValid}, 32'd0);
        chk("reset fetchCount", bus.fetchCount, 32'd0);
        chk("reset halted", {31'd0, bus.halted}, 32'd0);
        #6 reset = 1'b0;

        // Straight-line fetch of the whole program, then halt.
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("seq instr", bus.ifidInstruction, word(k));
            chk("seq addr", bus.readAddress, 32'(4 * (k + 1)));
        end
        chk("seq last word", bus.ifidInstruction, 32'h6666_6666);
        chk("seq count", bus.fetchCount, 32'd6);
        tick();
        chk("halt flag", {31'd0, bus.halted}, 32'd1);
        chk("halt pc", bus.readAddress, 32'd24);
        tick();
        chk("halt pc hold", bus.readAddress, 32'd24);
        chk("halt count", bus.fetchCount, 32'd6);

        // Redirect out of halt to a misaligned target.
        bus.branchTaken = 1'b1; bus.branchTarget = 32'h0000_0007;
        tick(); clear_ctl();
        chk("resume pc", bus.readAddress, 32'd4);
        chk("resume halted", {31'd0, bus.halted}, 32'd0);
        chk("resume valid", {31'd0, bus.ifidValid}, 32'd0);
        tick();
        chk("resume instr", bus.ifidInstruction, 32'h2222_2222);
        chk("resume count", bus.fetchCount, 32'd7);

        // Three-cycle stall at pc=8.
        bus.stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall pc", bus.readAddress, 32'd8);
            chk("stall instr", bus.ifidInstruction, 32'h2222_2222);
            chk("stall count", bus.fetchCount, 32'd7);
        end
        clear_ctl();
        tick();
        chk("unstall instr", bus.ifidInstruction, 32'h3333_3333);
        chk("unstall pc", bus.readAddress, 32'd12);

        // Backward branch from pc=12.
        bus.branchTaken = 1'b1; bus.branchTarget = 32'h0000_0004;
        tick(); clear_ctl();
        chk("branch pc", bus.readAddress, 32'd4);
        chk("branch flush", {31'd0, bus.ifidValid}, 32'd0);
        tick();
        chk("branch capture", bus.ifidInstruction, 32'h2222_2222);
        chk("branch pc4", bus.ifidPcPlus4, 32'd8);

        // Jump with branch and stall all asserted.
        bus.jump = 1'b1; bus.jumpIndex = 26'h2;
        bus.branchTaken = 1'b1; bus.branchTarget = 32'h0000_0014; bus.stall = 1'b1;
        tick(); clear_ctl();
        chk("jump pc", bus.readAddress, 32'd8);
        chk("jump flush valid", {31'd0, bus.ifidValid}, 32'd0);
        chk("jump flush instr", bus.ifidInstruction, 32'd0);
        chk("jump count", bus.fetchCount, 32'd9);
        tick();
        tick();
        chk("pre-reset pc", bus.readAddress, 32'd16);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        chk("async readAddress", bus.readAddress, 32'd0);
        chk("async ifidValid", {31'd0, bus.ifidValid}, 32'd0);
        chk("async ifidInstruction", bus.ifidInstruction, 32'd0);
        chk("async fetchCount", bus.fetchCount, 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        tick();
        chk("post-reset instr", bus.ifidInstruction, 32'h1111_1111);
        chk("post-reset count", bus.fetchCount, 32'd1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
